// File: rtl/axi_reader_pkg.sv
// Shared types and constants for the single-beat AXI read engine.
package axi_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // 64 bytes per beat, matching the 512-bit data bus
    localparam logic [2:0] AXI_SIZE_64B = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_reader.sv
// Issues one 64-byte AXI read per user request and returns the beat with status.
// Latency 4 cycles minimum (request to rready); AR/R stalls extend it, one read in flight.
module axi_reader
    import axi_reader_pkg::*;
#(
    parameter logic [15:0] ID_VALUE = 16'h0000
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         rvalid,
    input  logic [63:0]  raddr,
    output logic         rready,
    output logic [511:0] rdata,
    output logic [1:0]   rresp,
    output logic         rerr,
    output logic [31:0]  rcount,
    output logic [15:0]  m_axi_arid,
    output logic [63:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [15:0]  m_axi_rid,
    input  logic [511:0] m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);

    state_e       state_q,   state_d;
    logic [63:0]  addr_q,    addr_d;
    logic [511:0] rdata_q,   rdata_d;
    logic [1:0]   rresp_q,   rresp_d;
    logic         rerr_q,    rerr_d;
    logic [31:0]  rcount_q,  rcount_d;
    logic         rready_q,  rready_d;
    logic         arvalid_q, arvalid_d;
    logic         axi_rready_q, axi_rready_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rerr_d   = rerr_q;
        rcount_d = rcount_q;
        rready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rvalid) begin
                    state_d = ST_RD_ADDR;
                    addr_d  = raddr;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    rresp_d = m_axi_rresp;
                    rerr_d  = (m_axi_rid != ID_VALUE) || !m_axi_rlast;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rready_d = 1'b1;
                rcount_d = rcount_q + 32'd1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered from the next state so they track it exactly
        arvalid_d    = (state_d == ST_RD_ADDR);
        axi_rready_d = (state_d == ST_RD_DATA);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            rerr_q       <= 1'b0;
            rcount_q     <= '0;
            rready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            axi_rready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            rerr_q       <= rerr_d;
            rcount_q     <= rcount_d;
            rready_q     <= rready_d;
            arvalid_q    <= arvalid_d;
            axi_rready_q <= axi_rready_d;
        end
    end

    assign rready        = rready_q;
    assign rdata         = rdata_q;
    assign rresp         = rresp_q;
    assign rerr          = rerr_q;
    assign rcount        = rcount_q;
    assign m_axi_arid    = ID_VALUE;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE_64B;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = axi_rready_q;

endmodule

// File: tb/tb_axi_reader.sv
// Directed and randomized reads against a transaction-level model of the reader.
module tb_axi_reader;

    localparam logic [15:0] ID = 16'h1234;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         rvalid = 1'b0;
    logic [63:0]  raddr = '0;
    logic         rready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rerr;
    logic [31:0]  rcount;
    logic [15:0]  m_axi_arid;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [15:0]  m_axi_rid = '0;
    logic [511:0] m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = '0;
    logic         m_axi_rlast = 1'b0;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;

    axi_reader #(.ID_VALUE(ID)) dut (
        .clk(clk), .nreset(nreset), .rvalid(rvalid), .raddr(raddr),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rerr(rerr), .rcount(rcount),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int pulses = 0;

    // Model of the user-visible result registers
    logic [31:0]  exp_count = '0;
    logic [511:0] exp_rdata = '0;
    logic [1:0]   exp_rresp = '0;
    logic         exp_rerr = 1'b0;
    int           exp_pulses = 0;

    always @(posedge clk) if (rready === 1'b1) pulses++;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_rresp"}, {510'd0, rresp}, {510'd0, exp_rresp});
        check({tag, "_rerr"}, {511'd0, rerr}, {511'd0, exp_rerr});
        check({tag, "_rcount"}, {480'd0, rcount}, {480'd0, exp_count});
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Caller is positioned just after a negedge with the DUT idle (or about to be).
    task automatic do_read(input string tag, input logic [63:0] addr, input int ar_dly,
                           input int r_dly, input logic [511:0] d, input logic [1:0] resp,
                           input logic [15:0] rid_in, input logic rl, input bit hold,
                           input bit spur);
        int cyc = 0;
        int arw = 0;
        int rw = 0;
        int phase = 0;
        bit seen = 0;
        rvalid = 1'b1;
        raddr  = addr;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!hold) rvalid = 1'b0;
            raddr = {$urandom, $urandom};
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            if (rready === 1'b1) begin
                seen = 1;
            end else begin
                check({tag, "_arvalid"}, {511'd0, m_axi_arvalid}, {511'd0, phase == 0});
                check({tag, "_m_rready"}, {511'd0, m_axi_rready}, {511'd0, phase == 1});
                if (phase == 0) begin
                    check({tag, "_araddr"}, {448'd0, m_axi_araddr}, {448'd0, addr});
                    check({tag, "_arfix"}, {485'd0, m_axi_arid, m_axi_arlen, m_axi_arsize},
                          {485'd0, ID, 8'd0, 3'd6});
                    if (spur) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = ~d;
                        m_axi_rresp  = ~resp;
                        m_axi_rid    = ~rid_in;
                        m_axi_rlast  = ~rl;
                    end
                    if (arw == ar_dly) begin
                        m_axi_arready = 1'b1;
                        phase = 1;
                    end else arw++;
                end else if (phase == 1) begin
                    if (rw == r_dly) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = d;
                        m_axi_rresp  = resp;
                        m_axi_rid    = rid_in;
                        m_axi_rlast  = rl;
                        phase = 2;
                    end else rw++;
                end
            end
        end
        compared++;
        assert (seen) else begin
            mismatched++;
            $error("FAIL %s_timeout observed=no_rready expected=rready", tag);
        end
        exp_count  = exp_count + 32'd1;
        exp_rdata  = d;
        exp_rresp  = resp;
        exp_rerr   = (rid_in != ID) || !rl;
        exp_pulses++;
        check({tag, "_latency"}, 512'(cyc), 512'(4 + ar_dly + r_dly));
        check_results(tag);
        if (!hold) begin
            @(negedge clk);
            check({tag, "_pulse_end"}, {511'd0, rready}, 512'd0);
            check({tag, "_pulses"}, 512'(pulses), 512'(exp_pulses));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rready"}, {511'd0, rready}, 512'd0);
        check({tag, "_arvalid"}, {511'd0, m_axi_arvalid}, 512'd0);
        check({tag, "_m_rready"}, {511'd0, m_axi_rready}, 512'd0);
        check({tag, "_araddr"}, {448'd0, m_axi_araddr}, 512'd0);
        check_results(tag);
    endtask

    logic [511:0] pat_a;

    initial begin
        pat_a = rand512();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        do_read("basic", 64'h1000, 0, 0, pat_a, 2'b00, ID, 1'b1, 0, 0);
        do_read("ar_stall", 64'h1000, 5, 0, rand512(), 2'b00, ID, 1'b1, 0, 0);
        do_read("slverr", 64'h40, 0, 2, rand512(), 2'b10, 16'h0005, 1'b0, 0, 0);
        do_read("decerr", 64'h80, 1, 1, rand512(), 2'b11, ID, 1'b1, 0, 1);

        // Abort while waiting for the R beat
        rvalid = 1'b1;
        raddr  = 64'h3000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rvalid = 1'b0;
            m_axi_arready = m_axi_arvalid;
        end
        m_axi_arready = 1'b0;
        check("abort_in_rd_data", {511'd0, m_axi_rready}, {511'd0, 1'b1});
        nreset = 1'b0;
        #1;
        exp_count = '0;
        exp_rdata = '0;
        exp_rresp = '0;
        exp_rerr  = 1'b0;
        check_all_zero("abort");
        m_axi_rvalid = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("abort_hold");
        m_axi_rvalid = 1'b0;
        nreset = 1'b1;
        @(negedge clk);
        check("abort_pulses", 512'(pulses), 512'(exp_pulses));
        do_read("post_abort", 64'h4000, 0, 0, rand512(), 2'b00, ID, 1'b1, 0, 0);

        for (int n = 0; n < 8; n++) begin
            do_read("random", {$urandom, $urandom_range(0, 65535), 6'd0} & 64'hFFFF_FFFF_FFFF_FFC0,
                    $urandom_range(0, 3), $urandom_range(0, 3), rand512(),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? ID : 16'($urandom),
                    1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
        end

        // Back-to-back with the request held high
        for (int n = 0; n < 3; n++) begin
            do_read("b2b", 64'h8000 + 64'(n) * 64, 0, 0, rand512(), 2'b01, ID, 1'b1, 1, 0);
        end
        rvalid = 1'b0;
        @(negedge clk);
        check("b2b_pulses", 512'(pulses), 512'(exp_pulses));

        @(negedge clk);
        force dut.rcount_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.rcount_q;
        exp_count = 32'hFFFF_FFFF;
        do_read("wrap", 64'hC0, 0, 0, rand512(), 2'b00, ID, 1'b1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
